alu_seq: RTL
============

# alu_seq

Multi-cycle sequencer that borrows the shared 8-bit ALU from the core datapath to run bit-serial operations the single-cycle path cannot do in one instruction: population count (POPCNT) and parity (PARITY). Sits between the core's ALU control signals and the ALU: in idle it passes the core's request straight through; while busy it owns the ALU and raises Busy so the core stalls. The ALU itself is unchanged and instantiated beside this block.

## Interface
- WIDTH, 8, data width; must equal the ALU width.
- ITER_MAX, 8, maximum POPCNT iterations; equals WIDTH.

- Clk  in  1  clock; all state updates on the rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- Start  in  1  request pulse; sampled only in IDLE.
- Mode  in  1  0 = POPCNT, 1 = PARITY; sampled with Start.
- Operand  in  WIDTH  source value; sampled with Start.
- CoreOp  in  4  core's ALU opcode, passed through when not busy.
- CoreA  in  WIDTH  core's ALU InputA, passed through when not busy.
- CoreB  in  1  core's ALU InputB, passed through when not busy.
- AluOp  out  4  opcode to ALU.
- AluA  out  WIDTH  InputA to ALU.
- AluB  out  1  InputB to ALU.
- AluOut  in  WIDTH  ALU result.
- AluZero  in  1  ALU zero flag.
- Busy  out  1  sequencer owns the ALU; core must hold.
- Done  out  1  one-cycle pulse; Result valid.
- Result  out  WIDTH  last completed result; held until the next Done.

## Operation
- States: IDLE, MASK, ACC, SHIFT, PAR, DONE.
- Registers: sh (WIDTH), cnt (WIDTH), bit (1), iter (3 bits), res (WIDTH).
- IDLE: on Start=1, load sh=Operand, cnt=0, iter=0; go to MASK if Mode=0, PAR if Mode=1. Start=0 means stay.
- MASK: AluOp=kAND, AluA=sh, AluB=1; bit<=AluOut[0]; go to ACC.
- ACC: AluOp=kADD, AluA=cnt, AluB=bit; cnt<=AluOut; go to SHIFT.
- SHIFT: AluOp=kRSH, AluA=sh, AluB=0; sh<=AluOut; iter<=iter+1.
  - If AluZero=1 or iter==ITER_MAX-1: res<=cnt, go to DONE.
  - Otherwise go to MASK.
- PAR: AluOp=kR_XOR, AluA=sh, AluB=0; res<=AluOut; go to DONE.
- DONE: Done=1; go to IDLE. Start is ignored in DONE.
- Mux:
  - In IDLE and DONE, AluOp/AluA/AluB = CoreOp/CoreA/CoreB.
  - In every other state the sequencer drives them.
- Busy=1 in MASK, ACC, SHIFT and PAR; Busy=0 in IDLE and DONE.
- Result=res.
- Start while Busy or in DONE is dropped; it is not queued.
- POPCNT iterations N = max(1, index of highest set bit + 1); the early exit uses the zero flag after each shift.
- cnt cannot overflow: maximum value is WIDTH.

## Timing
- Reset (Reset_n=0 at an edge): state IDLE; sh, cnt, bit, iter and res all 0.
  - Outputs after reset: Busy=0, Done=0, Result=0, ALU ports = Core passthrough.
  - Reset applied mid-operation aborts it with no Done; Result returns to 0.
- Start is high in cycle 0 (IDLE). Each state lasts exactly one cycle.
- POPCNT:
  - Busy is high in cycles 1..3N.
  - Done is high in cycle 3N+1.
  - Latency ranges from 4 cycles (Operand ≤ 0x01) to 25 cycles (bit 7 set).
- PARITY: Busy is high in cycle 1; Done is high in cycle 2.
- Result changes only on the edge entering DONE, so it is stable from the Done cycle onward.
- Passthrough is purely combinational in IDLE and DONE: the core has the ALU in the Start cycle and in the Done cycle.
- Back-to-back: the earliest next Start is the cycle after Done.

## Structure
- Package definitions gains:
  - a seq_state_t enum (IDLE, MASK, ACC, SHIFT, PAR, DONE) for waveform viewing;
  - mode constants kSEQ_POPCNT=0 and kSEQ_PARITY=1.
- The block reuses the existing kADD, kAND, kRSH and kR_XOR opcodes from that package; it defines no new opcodes.
- Single module with no sub-modules. The ALU is instantiated by the parent and by the bench.

## Test plan
- Reset hold for 2 cycles, then release with no Start → Busy=0, Done=0, Result=0x00; AluOp/AluA/AluB track CoreOp/CoreA/CoreB every cycle.
- POPCNT Operand=0xFF → Busy cycles 1–24, Done in cycle 25, Result=0x08. POPCNT Operand=0xB5 → Done in cycle 25, Result=0x05.
- POPCNT Operand=0x00 → Done in cycle 4, Result=0x00. Operand=0x01 → Done in cycle 4, Result=0x01. Operand=0x80 → Done in cycle 25, Result=0x01.
- PARITY Operand=0x07 → Done in cycle 2, Result=0x01. PARITY Operand=0x0F → Result=0x00.
- Start pulses in cycles 3 and 25 of a 0xFF POPCNT → both ignored; exactly one Done.
- Reset_n=0 in cycle 10 of a 0xFF POPCNT → IDLE next cycle, no Done, Result=0x00; a new PARITY 0x01 then completes normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared ALU definitions plus sequencer state and mode encodings.
// Opcode values are those of the core's existing 8-bit ALU.
package alu_seq_pkg;

   localparam int kWIDTH    = 8;
   localparam int kITER_MAX = 8;

   localparam logic [3:0] kADD   = 4'h0;
   localparam logic [3:0] kAND   = 4'h2;
   localparam logic [3:0] kRSH   = 4'h6;
   localparam logic [3:0] kR_XOR = 4'h9;

   localparam logic kSEQ_POPCNT = 1'b0;
   localparam logic kSEQ_PARITY = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      MASK,
      ACC,
      SHIFT,
      PAR,
      DONE
   } seq_state_t;

endpackage

// File: rtl/alu_seq.sv
// Bit-serial POPCNT/PARITY sequencer that borrows the shared ALU
// while busy and passes the core's ALU controls through otherwise.
import alu_seq_pkg::*;

module alu_seq #(
   parameter int WIDTH    = kWIDTH,
   parameter int ITER_MAX = kITER_MAX
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_start,
   input  logic             i_mode,
   input  logic [WIDTH-1:0] i_operand,
   input  logic [3:0]       i_core_op,
   input  logic [WIDTH-1:0] i_core_a,
   input  logic             i_core_b,
   output logic [3:0]       o_alu_op,
   output logic [WIDTH-1:0] o_alu_a,
   output logic             o_alu_b,
   input  logic [WIDTH-1:0] i_alu_out,
   input  logic             i_alu_zero,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result
);

   seq_state_t       r_state;
   seq_state_t       w_state_nxt;
   logic [WIDTH-1:0] r_sh;
   logic [WIDTH-1:0] w_sh_nxt;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] w_cnt_nxt;
   logic             r_bit;
   logic             w_bit_nxt;
   logic [2:0]       r_iter;
   logic [2:0]       w_iter_nxt;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] w_res_nxt;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state <= IDLE;
         r_sh    <= '0;
         r_cnt   <= '0;
         r_bit   <= 1'b0;
         r_iter  <= '0;
         r_res   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sh    <= w_sh_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
         r_iter  <= w_iter_nxt;
         r_res   <= w_res_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sh_nxt    = r_sh;
      w_cnt_nxt   = r_cnt;
      w_bit_nxt   = r_bit;
      w_iter_nxt  = r_iter;
      w_res_nxt   = r_res;
      o_alu_op    = i_core_op;
      o_alu_a     = i_core_a;
      o_alu_b     = i_core_b;
      o_busy      = 1'b0;
      o_done      = 1'b0;

      unique case (r_state)
         IDLE: begin
            if (i_start) begin
               w_sh_nxt    = i_operand;
               w_cnt_nxt   = '0;
               w_iter_nxt  = '0;
               w_state_nxt = (i_mode == kSEQ_PARITY) ? PAR : MASK;
            end
         end
         MASK: begin
            o_busy      = 1'b1;
            o_alu_op    = kAND;
            o_alu_a     = r_sh;
            o_alu_b     = 1'b1;
            w_bit_nxt   = i_alu_out[0];
            w_state_nxt = ACC;
         end
         ACC: begin
            o_busy      = 1'b1;
            o_alu_op    = kADD;
            o_alu_a     = r_cnt;
            o_alu_b     = r_bit;
            w_cnt_nxt   = i_alu_out;
            w_state_nxt = SHIFT;
         end
         SHIFT: begin
            o_busy     = 1'b1;
            o_alu_op   = kRSH;
            o_alu_a    = r_sh;
            o_alu_b    = 1'b0;
            w_sh_nxt   = i_alu_out;
            w_iter_nxt = r_iter + 3'd1;
            // Zero flag ends the loop once no set bits remain above.
            if (i_alu_zero || r_iter == 3'(ITER_MAX - 1)) begin
               w_res_nxt   = r_cnt;
               w_state_nxt = DONE;
            end else begin
               w_state_nxt = MASK;
            end
         end
         PAR: begin
            o_busy      = 1'b1;
            o_alu_op    = kR_XOR;
            o_alu_a     = r_sh;
            o_alu_b     = 1'b0;
            w_res_nxt   = i_alu_out;
            w_state_nxt = DONE;
         end
         DONE: begin
            o_done      = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign o_result = r_res;

endmodule
